// File: rtl/med_sched_pkg.sv
// ----------------------------------------------------------------------------
// med_sched_pkg
// Shared definitions for the multi-slot medication scheduler.
//   cmd_op_e         command opcodes carried on cmd_op
//   log_ev_e         event type stored in the MSB of each log entry
//   log_entry_width  width of a packed log entry {type, idx, timestamp}
// ----------------------------------------------------------------------------
package med_sched_pkg;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_SET        = 3'd1,
        OP_DIS        = 3'd2,
        OP_ACK        = 3'd3,
        OP_CLR_LOG    = 3'd4,
        OP_SET_TIME   = 3'd5,
        OP_SET_PERIOD = 3'd6,
        OP_NOP_7      = 3'd7
    } cmd_op_e;

    typedef enum logic {
        EV_DUE = 1'b0,
        EV_ACK = 1'b1
    } log_ev_e;

    function automatic int log_entry_width(input int idx_w, input int time_w);
        return 1 + idx_w + time_w;
    endfunction

endpackage

// File: rtl/med_log_fifo.sv
// ----------------------------------------------------------------------------
// med_log_fifo
// First-word-fall-through FIFO for scheduler log entries.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous flush (pointers and count to zero)
//   push, wdata   write request / data; accepted when not full or when a
//                 pop happens in the same cycle
//   pop           remove head entry; ignored when empty
//   rdata         head entry, forced to 0 while empty
//   empty, full   status
//   count         occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module med_log_fifo #(
    parameter int  WIDTH = 12,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/med_sched_multi.sv
// ----------------------------------------------------------------------------
// med_sched_multi
// Multi-slot medication scheduler with a timestamped DUE/ACK event log.
// Optional feature macro: MED_SCHED_REPEAT_EN (per-slot repeat period, op 6).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ena             global enable; all state holds while low
//   cmd_valid/ready command handshake (cmd_ready = ena)
//   cmd_op/idx/data opcode, slot index, time or period operand
//   now             wall clock
//   due_vec, alarm  per-slot due flags and their OR
//   log_rd_en       pop the log head
//   log_rd_valid    log not empty
//   log_rd_data     {type, idx, timestamp} of the head entry
//   log_count       log occupancy
//   log_overflow    sticky: an event was dropped on a full log
// ----------------------------------------------------------------------------
module med_sched_multi
    import med_sched_pkg::*;
#(
    parameter int  NUM_MEDS  = 8,
    parameter int  TIME_W    = 8,
    parameter int  LOG_DEPTH = 16,
    parameter int  TICK_DIV  = 1,
    localparam int IDX_W     = $clog2(NUM_MEDS),
    localparam int ENTRY_W   = log_entry_width(IDX_W, TIME_W),
    localparam int CNT_W     = $clog2(LOG_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [IDX_W-1:0]    cmd_idx,
    input  logic [TIME_W-1:0]   cmd_data,
    output logic [TIME_W-1:0]   now,
    output logic [NUM_MEDS-1:0] due_vec,
    output logic                alarm,
    input  logic                log_rd_en,
    output logic                log_rd_valid,
    output logic [ENTRY_W-1:0]  log_rd_data,
    output logic [CNT_W-1:0]    log_count,
    output logic                log_overflow
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]    presc;
    logic [TIME_W-1:0]   now_q;
    logic [TIME_W-1:0]   due_time     [NUM_MEDS];
    logic [TIME_W-1:0]   due_time_nxt [NUM_MEDS];
    logic [NUM_MEDS-1:0] slot_en, slot_en_nxt;
    logic [NUM_MEDS-1:0] due_q, due_nxt;
    logic [NUM_MEDS-1:0] pend_due, pend_due_nxt;
    logic [NUM_MEDS-1:0] pend_ack, pend_ack_nxt;
    logic                overflow_q;
`ifdef MED_SCHED_REPEAT_EN
    logic [TIME_W-1:0]   period     [NUM_MEDS];
    logic [TIME_W-1:0]   period_nxt [NUM_MEDS];
    logic                op_set_period;
`endif

    cmd_op_e             op;
    logic                accept;
    logic                op_set, op_dis, op_ack, op_clr, op_set_time;
    logic                tick, fire_eval;
    logic [TIME_W-1:0]   now_inc;
    logic [NUM_MEDS-1:0] sel;
    logic [NUM_MEDS-1:0] fire, ack_ok;

    logic                log_req, log_pop, log_drop, log_type;
    logic [IDX_W-1:0]    log_idx;
    logic [NUM_MEDS-1:0] log_sel, log_clr_due, log_clr_ack;
    logic                fifo_empty, fifo_full;

    // ---------------- command decode ----------------
    assign cmd_ready   = ena;
    assign accept      = cmd_valid && ena;
    assign op          = cmd_op_e'(cmd_op);
    assign op_set      = accept && (op == OP_SET);
    assign op_dis      = accept && (op == OP_DIS);
    assign op_ack      = accept && (op == OP_ACK);
    assign op_clr      = accept && (op == OP_CLR_LOG);
    assign op_set_time = accept && (op == OP_SET_TIME);
`ifdef MED_SCHED_REPEAT_EN
    assign op_set_period = accept && (op == OP_SET_PERIOD);
`endif
    assign sel = NUM_MEDS'(1) << cmd_idx;

    // ---------------- wall clock ----------------
    assign tick      = ena && (presc == PRE_LAST);
    assign fire_eval = tick && !op_set_time;
    assign now_inc   = now_q + 1'b1;

    // Fire compares against the value `now` takes at this edge. An ACK
    // landing on a firing slot loses: the slot refires and the ACK vanishes.
    always_comb begin
        fire   = '0;
        ack_ok = '0;
        for (int i = 0; i < NUM_MEDS; i++) begin
            fire[i]   = fire_eval && slot_en[i] && (due_time[i] == now_inc)
                        && (!due_q[i] || (op_ack && sel[i]));
            ack_ok[i] = op_ack && sel[i] && due_q[i] && !fire[i];
        end
    end

    // ---------------- logger priority select ----------------
    always_comb begin
        log_idx  = '0;
        log_type = EV_DUE;
        for (int i = NUM_MEDS - 1; i >= 0; i--) begin
            if (pend_due[i]) log_idx = IDX_W'(i);
        end
        if (|pend_ack) begin
            log_type = EV_ACK;
            for (int i = NUM_MEDS - 1; i >= 0; i--) begin
                if (pend_ack[i]) log_idx = IDX_W'(i);
            end
        end
    end

    // No push on a CLR_LOG cycle, so pending events land after the flush.
    assign log_req     = ena && !op_clr && (|pend_ack || |pend_due);
    assign log_pop     = ena && !op_clr && log_rd_en;
    assign log_drop    = log_req && fifo_full && !(log_pop && !fifo_empty);
    assign log_sel     = NUM_MEDS'(1) << log_idx;
    assign log_clr_ack = (log_req && (log_type == EV_ACK)) ? log_sel : '0;
    assign log_clr_due = (log_req && (log_type == EV_DUE)) ? log_sel : '0;

    // ---------------- slot next state ----------------
    always_comb begin
        slot_en_nxt  = slot_en;
        due_nxt      = due_q;
        due_time_nxt = due_time;
        pend_due_nxt = pend_due & ~log_clr_due;
        pend_ack_nxt = pend_ack & ~log_clr_ack;
`ifdef MED_SCHED_REPEAT_EN
        period_nxt   = period;
`endif
        for (int i = 0; i < NUM_MEDS; i++) begin
            if (fire[i]) begin
                due_nxt[i]      = 1'b1;
                pend_due_nxt[i] = 1'b1;
            end
            if (ack_ok[i]) begin
                due_nxt[i]      = 1'b0;
                pend_ack_nxt[i] = 1'b1;
`ifdef MED_SCHED_REPEAT_EN
                if (period[i] != '0) due_time_nxt[i] = due_time[i] + period[i];
                else                 slot_en_nxt[i]  = 1'b0;
`endif
            end
            if (op_set && sel[i]) begin
                due_time_nxt[i] = cmd_data;
                slot_en_nxt[i]  = 1'b1;
                due_nxt[i]      = 1'b0;
            end
            if (op_dis && sel[i]) begin
                slot_en_nxt[i] = 1'b0;
                due_nxt[i]     = 1'b0;
            end
`ifdef MED_SCHED_REPEAT_EN
            if (op_set_period && sel[i]) period_nxt[i] = cmd_data;
`endif
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            now_q      <= '0;
            slot_en    <= '0;
            due_q      <= '0;
            pend_due   <= '0;
            pend_ack   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NUM_MEDS; i++) begin
                due_time[i] <= '0;
`ifdef MED_SCHED_REPEAT_EN
                period[i]   <= '0;
`endif
            end
        end else if (ena) begin
            if (op_set_time) begin
                presc <= '0;
                now_q <= cmd_data;
            end else if (tick) begin
                presc <= '0;
                now_q <= now_inc;
            end else begin
                presc <= presc + 1'b1;
            end
            slot_en  <= slot_en_nxt;
            due_q    <= due_nxt;
            pend_due <= pend_due_nxt;
            pend_ack <= pend_ack_nxt;
            for (int i = 0; i < NUM_MEDS; i++) begin
                due_time[i] <= due_time_nxt[i];
`ifdef MED_SCHED_REPEAT_EN
                period[i]   <= period_nxt[i];
`endif
            end
            if (op_clr)        overflow_q <= 1'b0;
            else if (log_drop) overflow_q <= 1'b1;
        end
    end

    med_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (op_clr),
        .push  (log_req),
        .wdata ({log_type, log_idx, now_q}),
        .pop   (log_pop),
        .rdata (log_rd_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (log_count)
    );

    assign now          = now_q;
    assign due_vec      = due_q;
    assign alarm        = |due_q;
    assign log_rd_valid = !fifo_empty;
    assign log_overflow = overflow_q;

endmodule

// File: tb/tb_med_sched_multi.sv
// ----------------------------------------------------------------------------
// tb_med_sched_multi
// Directed bench for med_sched_multi with default parameters
// (8 slots, 8-bit time, 16-entry log, TICK_DIV=1). Honors
// MED_SCHED_REPEAT_EN for the repeat-period scenario.
// ----------------------------------------------------------------------------
module tb_med_sched_multi;
    import med_sched_pkg::*;

    localparam int IDX_W   = 3;
    localparam int TIME_W  = 8;
    localparam int ENTRY_W = 12;
    localparam int CNT_W   = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               ena;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [IDX_W-1:0]   cmd_idx;
    logic [TIME_W-1:0]  cmd_data;
    logic [TIME_W-1:0]  now;
    logic [7:0]         due_vec;
    logic               alarm;
    logic               log_rd_en;
    logic               log_rd_valid;
    logic [ENTRY_W-1:0] log_rd_data;
    logic [CNT_W-1:0]   log_count;
    logic               log_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    med_sched_multi dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_idx      (cmd_idx),
        .cmd_data     (cmd_data),
        .now          (now),
        .due_vec      (due_vec),
        .alarm        (alarm),
        .log_rd_en    (log_rd_en),
        .log_rd_valid (log_rd_valid),
        .log_rd_data  (log_rd_data),
        .log_count    (log_count),
        .log_overflow (log_overflow)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] op, input int idx, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = IDX_W'(idx);
        cmd_data  = data;
        cyc();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
    endtask

    task automatic pop();
        log_rd_en = 1'b1;
        cyc();
        log_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_now(input logic [7:0] t);
        int n = 0;
        while (now !== t && n < 600) begin
            cyc();
            n++;
        end
        check("wait_now", 32'(now), 32'(t));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_now"},   32'(now),          32'd0);
        check({tag, "_due"},   32'(due_vec),      32'd0);
        check({tag, "_alarm"}, 32'(alarm),        32'd0);
        check({tag, "_cnt"},   32'(log_count),    32'd0);
        check({tag, "_vld"},   32'(log_rd_valid), 32'd0);
        check({tag, "_data"},  32'(log_rd_data),  32'd0);
        check({tag, "_ovf"},   32'(log_overflow), 32'd0);
    endtask

    initial begin
        logic [7:0] t_ack;
        logic [7:0] t_x;
        logic [7:0] t_hold;
        logic [7:0] seen;

        rst       = 1'b1;
        ena       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_idx   = '0;
        cmd_data  = '0;
        log_rd_en = 1'b0;
        cyc();
        cyc();
        check_all_zero("reset");

        // 1: single slot fires at 5 and is logged with timestamp 5
        rst = 1'b0;
        cmd(OP_SET, 2, 8'd5);
        wait_now(8'd5);
        check("t1_due",   32'(due_vec),   32'h04);
        check("t1_alarm", 32'(alarm),     32'd1);
        check("t1_cnt0",  32'(log_count), 32'd0);
        cyc();
        check("t1_vld",   32'(log_rd_valid), 32'd1);
        check("t1_data",  32'(log_rd_data),  32'h205);
        check("t1_cnt1",  32'(log_count),    32'd1);
        pop();
        check("t1_cnt_pop", 32'(log_count), 32'd0);

        // 2: two slots at the same time log in index order, then ACK idx3
        cmd(OP_DIS, 2, 8'd0);
        cmd(OP_SET_TIME, 0, 8'd0);
        check("t2_settime", 32'(now), 32'd0);
        cmd(OP_SET, 1, 8'd7);
        cmd(OP_SET, 3, 8'd7);
        wait_now(8'd7);
        check("t2_due", 32'(due_vec), 32'h0A);
        cyc();
        check("t2_cnt1",  32'(log_count),   32'd1);
        check("t2_head1", 32'(log_rd_data), 32'h107);
        cyc();
        check("t2_cnt2",  32'(log_count),   32'd2);
        pop();
        check("t2_head2", 32'(log_rd_data), 32'h308);
        pop();
        check("t2_empty", 32'(log_rd_valid), 32'd0);
        t_ack = now + 8'd1;
        cmd(OP_ACK, 3, 8'd0);
        check("t2_due_ack", 32'(due_vec), 32'h02);
        cyc();
        check("t2_ack_entry", 32'(log_rd_data), 32'({1'b1, 3'd3, t_ack}));
        pop();

        // ena low freezes everything, including command acceptance
        t_hold    = now;
        ena       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_SET_TIME;
        cmd_data  = 8'hAA;
        repeat (5) cyc();
        check("ena_now",   32'(now),       32'(t_hold));
        check("ena_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        ena       = 1'b1;

        // 3: fill the log, overflow on one more event, then clear
        do_reset();
        for (int i = 0; i < 8; i++) cmd(OP_SET, i, 8'd20);
        wait_now(8'd20);
        check("t3_due_all", 32'(due_vec), 32'hFF);
        for (int i = 0; i < 8; i++) cmd(OP_ACK, i, 8'd0);
        repeat (12) cyc();
        check("t3_full_cnt",  32'(log_count),    32'd16);
        check("t3_full_ovf",  32'(log_overflow), 32'd0);
        check("t3_full_head", 32'(log_rd_data),  32'h014);
        t_x = now + 8'd5;
        cmd(OP_SET, 0, t_x);
        wait_now(t_x);
        cyc();
        check("t3_ovf",      32'(log_overflow), 32'd1);
        check("t3_ovf_cnt",  32'(log_count),    32'd16);
        check("t3_ovf_head", 32'(log_rd_data),  32'h014);
        cmd(OP_CLR_LOG, 0, 8'd0);
        check("t3_clr_cnt", 32'(log_count),    32'd0);
        check("t3_clr_ovf", 32'(log_overflow), 32'd0);
        check("t3_clr_vld", 32'(log_rd_valid), 32'd0);

        // 4: ACK in the refire cycle loses; slot stays due, only DUE logged
        do_reset();
        cmd(OP_SET, 0, 8'd3);
        wait_now(8'd3);
        check("t4_due", 32'(due_vec), 32'h01);
        cyc();
        pop();
        wait_now(8'd2);
        cmd(OP_ACK, 0, 8'd0);
        check("t4_now",     32'(now),     32'd3);
        check("t4_due_win", 32'(due_vec), 32'h01);
        cyc();
        cyc();
        check("t4_cnt",   32'(log_count),   32'd1);
        check("t4_entry", 32'(log_rd_data), 32'h003);

        // 5: repeat period (or its absence)
        do_reset();
        cmd(OP_SET, 0, 8'd10);
        cmd(OP_SET_PERIOD, 0, 8'd20);
        wait_now(8'd12);
        check("t5_due", 32'(due_vec), 32'h01);
        cmd(OP_ACK, 0, 8'd0);
        check("t5_acked", 32'(due_vec), 32'h00);
`ifdef MED_SCHED_REPEAT_EN
        wait_now(8'd29);
        check("t5_pre30", 32'(due_vec), 32'h00);
        cyc();
        check("t5_refire30", 32'(due_vec), 32'h01);
        cmd(OP_SET_PERIOD, 0, 8'd0);
        cmd(OP_ACK, 0, 8'd0);
        check("t5_oneshot_ack", 32'(due_vec), 32'h00);
        seen = 8'h00;
        for (int i = 0; i < 300; i++) begin
            cyc();
            seen = seen | due_vec;
        end
        check("t5_no_refire", 32'(seen), 32'h00);
`else
        wait_now(8'd30);
        check("t5_no_period", 32'(due_vec), 32'h00);
        wait_now(8'd10);
        check("t5_wrap_refire", 32'(due_vec), 32'h01);
        seen = 8'h00;
        check("t5_seen_init", 32'(seen | due_vec), 32'h01);
`endif

        // 6: reset with three DUE events still pending discards them
        do_reset();
        cmd(OP_SET, 0, 8'd5);
        cmd(OP_SET, 1, 8'd5);
        cmd(OP_SET, 2, 8'd5);
        wait_now(8'd5);
        check("t6_due", 32'(due_vec), 32'h07);
        rst = 1'b1;
        cyc();
        check_all_zero("t6_rst");
        rst = 1'b0;
        repeat (10) cyc();
        check("t6_cnt_after", 32'(log_count),    32'd0);
        check("t6_vld_after", 32'(log_rd_valid), 32'd0);
        check("t6_due_after", 32'(due_vec),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
